// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: register map,
// register bit positions and the loader state encoding.
package fpga_cfg_pkg;

    localparam int unsigned COUNT_W = 16;

    localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
    localparam logic [31:0] REG_DATA   = 32'h0000_0004;
    localparam logic [31:0] REG_STATUS = 32'h0000_0008;

    localparam int unsigned CTRL_ABORT  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_DONE      = 1;
    localparam int unsigned STATUS_OVERRUN   = 2;
    localparam int unsigned STATUS_COUNT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cfg_serializer.sv
// Holds one bitstream word and presents it CHAINS bits at a time, low bits
// first; last_c flags the shift cycle that consumes the final slice.
module cfg_serializer
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CHAINS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              flush,
    input  logic [31:0]       word,
    output logic [CHAINS-1:0] data,
    output logic              last_c
);

    localparam int unsigned WORD_CYCLES = 32 / CHAINS;
    localparam int unsigned CNT_W       = $clog2(WORD_CYCLES + 1);

    logic [31:0]      sr;
    logic [CNT_W-1:0] remaining;

    // Flush wins so aborted or truncated words never leak onto the chains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            remaining <= '0;
        end else if (flush) begin
            sr        <= '0;
            remaining <= '0;
        end else if (load) begin
            sr        <= word;
            remaining <= CNT_W'(WORD_CYCLES);
        end else if (shift && (remaining != '0)) begin
            sr        <= sr >> CHAINS;
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign data   = sr[CHAINS-1:0];
    assign last_c = (remaining == CNT_W'(1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone slave that accepts bitstream words and serialises them across the
// fabric configuration chains, then latches and enables the fabric.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CHAINS    = 4,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [CHAINS-1:0] cfg_data_o,
    output logic              cfg_shift_o,
    output logic              cfg_latch_o,
    output logic              fabric_en_o,
    output logic              irq_o
);

    localparam logic [31:0]        WIN_MASK  = 32'((64'd1 << ADDR_BITS) - 64'd1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(CHAIN_LEN);

    state_t             state, state_next;
    logic               ack, ack_next;
    logic [31:0]        rdata, rdata_next;
    logic               irq_en, irq_en_next;
    logic               done_flag, done_next;
    logic               overrun, overrun_next;
    logic [COUNT_W-1:0] count, count_next;
    logic               shift_q, shift_next;
    logic               latch_q, latch_next;
    logic               fabric_q, fabric_next;
    logic               irq_q, irq_next;

    logic [31:0] offset_c;
    logic        hit_c, req_c, busy_c, hold_c, accept_c, wr_c;
    logic        is_ctrl_c, is_data_c, is_status_c;
    logic        data_wr_c, abort_c, load_c, flush_c, last_c;
    logic        sel_unused;

    assign sel_unused = ^wbs_sel_i;

    // Address decode; a DATA write is stalled (no ack) while the chains are busy.
    assign hit_c       = ((wbs_adr_i & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK));
    assign offset_c    = wbs_adr_i & WIN_MASK & ~32'd3;
    assign is_ctrl_c   = (offset_c == REG_CTRL);
    assign is_data_c   = (offset_c == REG_DATA);
    assign is_status_c = (offset_c == REG_STATUS);
    assign busy_c      = (state == SHIFT) || (state == LATCH);
    assign req_c       = wbs_cyc_i && wbs_stb_i && hit_c && !ack;
    assign hold_c      = wbs_we_i && is_data_c && busy_c;
    assign accept_c    = req_c && !hold_c;
    assign wr_c        = accept_c && wbs_we_i;
    assign data_wr_c   = wr_c && is_data_c;
    assign abort_c     = wr_c && is_ctrl_c && wbs_dat_i[CTRL_ABORT];
    assign load_c      = data_wr_c && (state == IDLE);
    assign flush_c     = abort_c || (state_next == LATCH);

    cfg_serializer #(
        .CHAINS (CHAINS)
    ) u_serializer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .load   (load_c),
        .shift  (state == SHIFT),
        .flush  (flush_c),
        .word   (wbs_dat_i),
        .data   (cfg_data_o),
        .last_c (last_c)
    );

    always_comb begin
        state_next   = state;
        count_next   = count;
        irq_en_next  = irq_en;
        done_next    = done_flag;
        overrun_next = overrun;
        ack_next     = accept_c;
        rdata_next   = '0;

        unique case (state)
            IDLE: begin
                if (data_wr_c) state_next = SHIFT;
            end
            SHIFT: begin
                if (count != COUNT_MAX) count_next = count + COUNT_W'(1);
                if (count == COUNT_MAX - COUNT_W'(1)) state_next = LATCH;
                else if (last_c)                      state_next = IDLE;
            end
            LATCH: begin
                state_next = DONE;
                done_next  = 1'b1;
            end
            DONE: begin
                if (data_wr_c) overrun_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (wr_c && is_ctrl_c) irq_en_next = wbs_dat_i[CTRL_IRQ_EN];
        if (wr_c && is_status_c) begin
            if (wbs_dat_i[STATUS_DONE])    done_next    = 1'b0;
            if (wbs_dat_i[STATUS_OVERRUN]) overrun_next = 1'b0;
        end

        // Abort overrides both the bus updates and load completion.
        if (abort_c) begin
            state_next = IDLE;
            count_next = '0;
            done_next  = 1'b0;
        end

        if (accept_c && !wbs_we_i) begin
            if (is_ctrl_c) begin
                rdata_next[CTRL_IRQ_EN] = irq_en;
            end else if (is_status_c) begin
                rdata_next[STATUS_BUSY]                          = busy_c;
                rdata_next[STATUS_DONE]                          = done_flag;
                rdata_next[STATUS_OVERRUN]                       = overrun;
                rdata_next[STATUS_COUNT_LSB +: COUNT_W]          = count;
            end
        end

        shift_next  = (state_next == SHIFT);
        latch_next  = (state_next == LATCH);
        fabric_next = (state_next == DONE);
        irq_next    = done_next && irq_en_next;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            ack       <= 1'b0;
            rdata     <= '0;
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            overrun   <= 1'b0;
            count     <= '0;
            shift_q   <= 1'b0;
            latch_q   <= 1'b0;
            fabric_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state     <= state_next;
            ack       <= ack_next;
            rdata     <= rdata_next;
            irq_en    <= irq_en_next;
            done_flag <= done_next;
            overrun   <= overrun_next;
            count     <= count_next;
            shift_q   <= shift_next;
            latch_q   <= latch_next;
            fabric_q  <= fabric_next;
            irq_q     <= irq_next;
        end
    end

    assign wbs_ack_o   = ack;
    assign wbs_dat_o   = rdata;
    assign cfg_shift_o = shift_q;
    assign cfg_latch_o = latch_q;
    assign fabric_en_o = fabric_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: a nibble-queue model predicts every output each
// cycle, and directed sequences pin key values with hand-computed literals.
module tb_fpga_cfg_loader;

    localparam int unsigned CHAINS    = 4;
    localparam int unsigned CHAIN_LEN = 16;
    localparam int unsigned NIBBLES   = 32 / CHAINS;
    localparam logic [31:0] BASE      = 32'h3000_0000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h0;
    localparam logic [31:0] A_DATA    = BASE + 32'h4;
    localparam logic [31:0] A_STATUS  = BASE + 32'h8;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              cyc  = 1'b0;
    logic              stb  = 1'b0;
    logic              we   = 1'b0;
    logic [3:0]        sel  = 4'hF;
    logic [31:0]       adr  = '0;
    logic [31:0]       wdat = '0;
    logic              ack;
    logic [31:0]       rdat;
    logic [CHAINS-1:0] cdata;
    logic              cshift, clatch, fab, irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpga_cfg_loader #(
        .CHAINS    (CHAINS),
        .CHAIN_LEN (CHAIN_LEN),
        .BASE_ADDR (BASE),
        .ADDR_BITS (4)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .cfg_data_o  (cdata),
        .cfg_shift_o (cshift),
        .cfg_latch_o (clatch),
        .fabric_en_o (fab),
        .irq_o       (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a queue of nibbles, one leaves per cycle.
    int          q[$];
    int          cnt       = 0;
    bit          in_done   = 0;
    bit          done_bit  = 0;
    bit          ovr       = 0;
    bit          irq_en_m  = 0;
    bit          e_shift   = 0;
    bit          e_latch   = 0;
    bit          e_fab     = 0;
    bit          e_irq     = 0;
    bit          e_ack     = 0;
    logic [3:0]  e_data    = '0;
    logic [31:0] e_dat     = '0;
    bit          m_hit, m_busy, m_req, m_acc, n_latch;
    logic [31:0] m_off, m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cnt = 0; in_done = 0; done_bit = 0; ovr = 0; irq_en_m = 0;
            e_shift = 0; e_latch = 0; e_fab = 0; e_irq = 0; e_ack = 0;
            e_data = '0; e_dat = '0;
        end else begin
            m_hit  = ((adr & ~32'hF) == BASE);
            m_off  = adr & 32'hC;
            m_busy = e_shift || e_latch;
            m_req  = cyc && stb && m_hit && !e_ack;
            m_acc  = m_req && !(we && m_off == 32'h4 && m_busy);
            m_rd   = '0;
            if (m_acc && !we) begin
                if (m_off == 32'h0)      m_rd = {30'd0, irq_en_m, 1'b0};
                else if (m_off == 32'h8) m_rd = {16'(cnt), 13'd0, ovr, done_bit, m_busy};
            end
            n_latch = 0;
            if (e_shift) begin
                if (cnt < CHAIN_LEN) cnt++;
                if (cnt == CHAIN_LEN) begin q.delete(); n_latch = 1; end
            end
            if (e_latch) begin in_done = 1; done_bit = 1; end
            if (m_acc && we) begin
                if (m_off == 32'h4) begin
                    if (in_done) ovr = 1;
                    else for (int i = 0; i < NIBBLES; i++) q.push_back(int'((wdat >> (4 * i)) & 32'hF));
                end else if (m_off == 32'h0) begin
                    irq_en_m = wdat[1];
                end else if (m_off == 32'h8) begin
                    if (wdat[1]) done_bit = 0;
                    if (wdat[2]) ovr = 0;
                end
                if (m_off == 32'h0 && wdat[0]) begin
                    q.delete(); n_latch = 0; cnt = 0; in_done = 0; done_bit = 0;
                end
            end
            e_shift = (q.size() > 0);
            e_data  = '0;
            if (e_shift) e_data = 4'(q.pop_front());
            e_latch = n_latch;
            e_fab   = in_done;
            e_irq   = done_bit && irq_en_m;
            e_ack   = m_acc;
            e_dat   = m_rd;
        end
    end

    logic [3:0] cap[$];
    int         latch_cnt = 0;
    bit         run_cmp   = 1;

    function automatic logic [31:0] pack_word(input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < NIBBLES; i++) w |= 32'(cap[base + i]) << (4 * i);
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input int budget,
                       output logic [31:0] r, output bit got, output int waited);
        got = 0; r = '0; waited = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        while (!got && waited < budget) begin
            @(posedge clk); #1;
            waited++;
            if (ack) begin got = 1; r = rdat; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; bit got; int waited;
        bus(1'b1, a, d, 64, r, got, waited);
        check({name, "_ack"}, 32'(got), 32'd1);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; bit got; int waited;
        bus(1'b0, a, 32'd0, 64, r, got, waited);
        check({name, "_ack"}, 32'(got), 32'd1);
        check(name, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        bit          got;
        int          waited;
        int          base, lbase;

        fork
            forever begin
                @(negedge clk);
                if (cshift) cap.push_back(cdata);
                if (clatch) latch_cnt++;
                if (run_cmp) begin
                    check("m_ack",    32'(ack),    32'(e_ack));
                    check("m_rdata",  rdat,        e_dat);
                    check("m_shift",  32'(cshift), 32'(e_shift));
                    if (e_shift) check("m_cdata", 32'(cdata), 32'(e_data));
                    check("m_latch",  32'(clatch), 32'(e_latch));
                    check("m_fabric", 32'(fab),    32'(e_fab));
                    check("m_irq",    32'(irq),    32'(e_irq));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_shift",  32'(cshift), 32'd0);
        check("rst_fabric", 32'(fab),    32'd0);
        check("rst_ack",    32'(ack),    32'd0);
        rst = 1'b0;
        idle(2);
        rd("reset_status", A_STATUS, 32'h0000_0000);

        // One word: eight slices 0..7, busy mid-way, count 8 after.
        base = cap.size();
        wr("t1_data", A_DATA, 32'h7654_3210);
        rd("t1_busy_status", A_STATUS, 32'h0001_0001);
        idle(10);
        check("t1_shift_cycles", 32'(cap.size() - base), 32'd8);
        check("t1_word", pack_word(base), 32'h7654_3210);
        rd("t1_status", A_STATUS, 32'h0008_0000);

        wr("irq_en", A_CTRL, 32'h2);
        rd("ctrl_read", A_CTRL, 32'h2);

        // Second word completes the 16-cycle load.
        base = cap.size(); lbase = latch_cnt;
        wr("t2_data", A_DATA, 32'hFEDC_BA98);
        idle(12);
        check("t2_word", pack_word(base), 32'hFEDC_BA98);
        check("t2_latch_pulses", 32'(latch_cnt - lbase), 32'd1);
        check("t2_fabric", 32'(fab), 32'd1);
        check("t2_irq", 32'(irq), 32'd1);
        rd("t2_status", A_STATUS, 32'h0010_0002);
        wr("t2_clear_done", A_STATUS, 32'h2);
        idle(2);
        check("t2_irq_cleared", 32'(irq), 32'd0);
        check("t2_fabric_kept", 32'(fab), 32'd1);

        // Write after completion: acked, discarded, overrun flagged.
        base = cap.size();
        wr("t4_data", A_DATA, 32'h1234_5678);
        idle(4);
        check("t4_no_shift", 32'(cap.size() - base), 32'd0);
        rd("t4_status", A_STATUS, 32'h0010_0004);

        // Abort out of DONE, then abort a fresh load at its fifth shift.
        wr("t5_abort_done", A_CTRL, 32'h3);
        rd("t5_status_a", A_STATUS, 32'h0000_0004);
        check("t5_fabric_off", 32'(fab), 32'd0);
        wr("t5_clear_ovr", A_STATUS, 32'h4);
        base = cap.size();
        wr("t5_data", A_DATA, 32'hA5A5_A5A5);
        idle(4);
        wr("t5_abort", A_CTRL, 32'h3);
        idle(2);
        check("t5_shifts_before_abort", 32'(cap.size() - base), 32'd5);
        rd("t5_status_b", A_STATUS, 32'h0000_0000);

        // Back-to-back words: second is stalled until the first has drained.
        base = cap.size(); lbase = latch_cnt;
        wr("t3_data_a", A_DATA, 32'h89AB_CDEF);
        bus(1'b1, A_DATA, 32'h0123_4567, 64, r, got, waited);
        check("t3_data_b_ack", 32'(got), 32'd1);
        check("t3_hold_cycles", 32'(waited), 32'd9);
        idle(12);
        check("t3_shift_cycles", 32'(cap.size() - base), 32'd16);
        check("t3_word_a", pack_word(base), 32'h89AB_CDEF);
        check("t3_word_b", pack_word(base + 8), 32'h0123_4567);
        check("t3_latch_pulses", 32'(latch_cnt - lbase), 32'd1);
        check("t3_fabric", 32'(fab), 32'd1);
        rd("t3_status", A_STATUS, 32'h0010_0002);

        // Asynchronous reset in the middle of a word.
        wr("t6_abort", A_CTRL, 32'h1);
        wr("t6_data", A_DATA, 32'hCAFE_F00D);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_shift",  32'(cshift), 32'd0);
        check("t6_rst_data",   32'(cdata),  32'd0);
        check("t6_rst_latch",  32'(clatch), 32'd0);
        check("t6_rst_fabric", 32'(fab),    32'd0);
        check("t6_rst_irq",    32'(irq),    32'd0);
        check("t6_rst_ack",    32'(ack),    32'd0);
        check("t6_rst_rdata",  rdat,        32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        rd("t6_status", A_STATUS, 32'h0000_0000);

        // Just outside the 16-byte window: never acknowledged.
        bus(1'b0, BASE + 32'h10, 32'd0, 16, r, got, waited);
        check("oow_no_ack", 32'(got), 32'd0);

        idle(2);
        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
